// File: rtl/wb_dmem_slave_if.sv
// Wishbone B4 pipelined bus bundle between the memory stage (master) and the data memory (slave).
// o_wb_err exists only when WB_DMEM_ERR_EN is defined.
interface wb_dmem_slave_if;
    logic        i_wb_cycle;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [3:0]  i_wb_sel;
    logic [29:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic [31:0] o_wb_data;
    logic        o_wb_stall;
`ifdef WB_DMEM_ERR_EN
    logic        o_wb_err;
`endif

    modport master (
        output i_wb_cycle, i_wb_stb, i_wb_we, i_wb_sel, i_wb_addr, i_wb_data,
`ifdef WB_DMEM_ERR_EN
        input  o_wb_err,
`endif
        input  o_wb_ack, o_wb_data, o_wb_stall
    );

    modport slave (
        input  i_wb_cycle, i_wb_stb, i_wb_we, i_wb_sel, i_wb_addr, i_wb_data,
`ifdef WB_DMEM_ERR_EN
        output o_wb_err,
`endif
        output o_wb_ack, o_wb_data, o_wb_stall
    );
endinterface

// File: rtl/wb_dmem_slave.sv
// Pipelined Wishbone data-memory slave: byte-lane writes, fixed-latency acks, stall on outstanding limit.
// Define WB_DMEM_ERR_EN to answer out-of-range addresses with o_wb_err instead of aliasing.
//
// state | meaning
// IDLE  | no accepted request awaiting its response
// BUSY  | some responses outstanding, more may be accepted
// FULL  | MAX_OUTSTANDING responses outstanding, stall unless the head retires now
module wb_dmem_slave #(
    parameter int ADDR_WIDTH      = 14,
    parameter int WAIT_STATES     = 0,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic             clk,
    input  logic             reset,
    wb_dmem_slave_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;

    state_t                  state, state_next;
    logic [2:0]              count, count_next;
    logic                    accept, retire, addr_err, wr_en;
    logic [ADDR_WIDTH-1:0]   word_idx;
    logic [31:0]             mem [0:(2**ADDR_WIDTH)-1];
    logic [WAIT_STATES:0]    pipe_valid, pipe_rd, pipe_err;
    logic [31:0]             pipe_data [0:WAIT_STATES];

    assign word_idx = bus.i_wb_addr[ADDR_WIDTH-1:0];

`ifdef WB_DMEM_ERR_EN
    assign addr_err = |(bus.i_wb_addr >> ADDR_WIDTH);
`else
    // Upper address bits are deliberately ignored so the RAM aliases.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.i_wb_addr;
    assign addr_err       = 1'b0;
`endif

    // The head response leaves at the coming edge, freeing a slot for a same-edge accept.
    assign retire         = pipe_valid[WAIT_STATES];
    assign bus.o_wb_stall = (state == FULL) && !retire;
    assign accept         = bus.i_wb_cycle && bus.i_wb_stb && !bus.o_wb_stall;
    assign wr_en          = accept && bus.i_wb_we && !addr_err;

    always_comb begin
        count_next = count;
        if (!bus.i_wb_cycle) begin
            count_next = 3'd0;
        end else begin
            case ({accept, retire})
                2'b10:   count_next = count + 3'd1;
                2'b01:   count_next = count - 3'd1;
                default: count_next = count;
            endcase
        end
        if (count_next == 3'd0)
            state_next = IDLE;
        else if (count_next == 3'(MAX_OUTSTANDING))
            state_next = FULL;
        else
            state_next = BUSY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= 3'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Dropping the cycle abandons every in-flight response; committed writes stay.
    always_ff @(posedge clk) begin
        if (reset || !bus.i_wb_cycle) begin
            pipe_valid <= '0;
            pipe_rd    <= '0;
            pipe_err   <= '0;
        end else begin
            pipe_valid[0] <= accept;
            pipe_rd[0]    <= accept && !bus.i_wb_we && !addr_err;
            pipe_err[0]   <= accept && addr_err;
            for (int i = 1; i <= WAIT_STATES; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_rd[i]    <= pipe_rd[i-1];
                pipe_err[i]   <= pipe_err[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (bus.i_wb_sel[n])
                    mem[word_idx][8*n +: 8] <= bus.i_wb_data[8*n +: 8];
            end
        end
        if (accept && !bus.i_wb_we)
            pipe_data[0] <= mem[word_idx];
        for (int i = 1; i <= WAIT_STATES; i++)
            pipe_data[i] <= pipe_data[i-1];
    end

    assign bus.o_wb_ack  = pipe_valid[WAIT_STATES] && !pipe_err[WAIT_STATES];
    assign bus.o_wb_data = (pipe_valid[WAIT_STATES] && pipe_rd[WAIT_STATES]) ?
                           pipe_data[WAIT_STATES] : 32'd0;
`ifdef WB_DMEM_ERR_EN
    assign bus.o_wb_err  = pipe_valid[WAIT_STATES] && pipe_err[WAIT_STATES];
`endif
endmodule

// File: tb/tb_wb_dmem_slave.sv
// Scoreboard bench for wb_dmem_slave: directed requests push expected responses, a negedge monitor checks them.
module tb_wb_dmem_slave;
    localparam int AW  = 14;
    localparam int WS  = 2;
    localparam int MAX = 2;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc_cnt = 0;
    int   acc_cnt = 0;
    int   rsp_cnt = 0;
    int   flushed = 0;
    exp_t exp_q[$];
    logic rsp_ack, rsp_err;

    wb_dmem_slave_if bus();

    wb_dmem_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS), .MAX_OUTSTANDING(MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    assign rsp_ack = bus.o_wb_ack;
`ifdef WB_DMEM_ERR_EN
    assign rsp_err = bus.o_wb_err;
`else
    assign rsp_err = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: every response pops the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rsp_ack || rsp_err) begin
            chk("ack_err_exclusive", {31'd0, rsp_ack && rsp_err}, 32'd0);
            chk("outstanding_limit", {31'd0, (acc_cnt - rsp_cnt - flushed) > MAX}, 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_response: ack=%b err=%b data=%h", rsp_ack, rsp_err, bus.o_wb_data);
            end else begin
                e = exp_q.pop_front();
                chk("resp_kind_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("resp_data", bus.o_wb_data, e.data);
                chk("resp_latency_cycle", cyc_cnt, e.cyc);
            end
            rsp_cnt++;
        end else if (bus.o_wb_data !== 32'd0) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_data_zero: got %h expected 00000000", bus.o_wb_data);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with stb still high.
    task automatic issue(input logic we, input logic [3:0] sel, input logic [29:0] addr,
                         input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_data);
        int   n;
        exp_t e;
        bus.i_wb_cycle = 1'b1;
        bus.i_wb_stb   = 1'b1;
        bus.i_wb_we    = we;
        bus.i_wb_sel   = sel;
        bus.i_wb_addr  = addr;
        bus.i_wb_data  = wdata;
        n = 0;
        while (bus.o_wb_stall && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.o_wb_stall) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_timeout: stall still %b after %0d cycles, required 0", bus.o_wb_stall, n);
        end else begin
            e.err  = exp_err;
            e.data = exp_data;
            e.cyc  = cyc_cnt + 1 + WS;
            exp_q.push_back(e);
            @(posedge clk);
            acc_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic idle();
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
    endtask

    task automatic drain();
        int n;
        idle();
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d responses pending, required 0", exp_q.size());
            flushed += exp_q.size();
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_wb_cycle = 1'b0;
        bus.i_wb_stb   = 1'b0;
        bus.i_wb_we    = 1'b0;
        bus.i_wb_sel   = 4'h0;
        bus.i_wb_addr  = 30'd0;
        bus.i_wb_data  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ack", {31'd0, bus.o_wb_ack}, 32'd0);
        chk("reset_data", bus.o_wb_data, 32'd0);
        chk("reset_stall", {31'd0, bus.o_wb_stall}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Write then immediate read of the same word.
        issue(1'b1, 4'hF, 30'd5, 32'hDEADBEEF, 1'b0, 32'h0);
        issue(1'b0, 4'hF, 30'd5, 32'h0, 1'b0, 32'hDEADBEEF);
        drain();

        // Byte-lane merge and a no-op sel=0000 write.
        issue(1'b1, 4'hF, 30'd9, 32'hAABBCCDD, 1'b0, 32'h0);
        issue(1'b1, 4'b0100, 30'd9, 32'h11223344, 1'b0, 32'h0);
        issue(1'b0, 4'hF, 30'd9, 32'h0, 1'b0, 32'hAA22CCDD);
        issue(1'b1, 4'b0000, 30'd9, 32'hFFFFFFFF, 1'b0, 32'h0);
        issue(1'b1, 4'b1001, 30'd10, 32'h5566_7788, 1'b0, 32'h0);
        issue(1'b0, 4'hF, 30'd9, 32'h0, 1'b0, 32'hAA22CCDD);
        drain();

        // Preload words 0..3, then hold four reads back to back.
        issue(1'b1, 4'hF, 30'd0, 32'hCAFE0000, 1'b0, 32'h0);
        issue(1'b1, 4'hF, 30'd1, 32'hCAFE0011, 1'b0, 32'h0);
        issue(1'b1, 4'hF, 30'd2, 32'hCAFE0022, 1'b0, 32'h0);
        issue(1'b1, 4'hF, 30'd3, 32'hCAFE0033, 1'b0, 32'h0);
        drain();
        issue(1'b0, 4'hF, 30'd0, 32'h0, 1'b0, 32'hCAFE0000);
        chk("no_stall_after_1st", {31'd0, bus.o_wb_stall}, 32'd0);
        issue(1'b0, 4'hF, 30'd1, 32'h0, 1'b0, 32'hCAFE0011);
        chk("stall_after_2nd", {31'd0, bus.o_wb_stall}, 32'd1);
        issue(1'b0, 4'hF, 30'd2, 32'h0, 1'b0, 32'hCAFE0022);
        issue(1'b0, 4'hF, 30'd3, 32'h0, 1'b0, 32'hCAFE0033);
        drain();

        // Abort: two reads in flight, cycle dropped before either acks.
        issue(1'b0, 4'hF, 30'd0, 32'h0, 1'b0, 32'hCAFE0000);
        issue(1'b0, 4'hF, 30'd1, 32'h0, 1'b0, 32'hCAFE0011);
        bus.i_wb_cycle = 1'b0;
        bus.i_wb_stb   = 1'b0;
        flushed += exp_q.size();
        exp_q.delete();
        repeat (6) @(negedge clk);
        chk("abort_stall_clear", {31'd0, bus.o_wb_stall}, 32'd0);
        issue(1'b0, 4'hF, 30'd2, 32'h0, 1'b0, 32'hCAFE0022);
        chk("abort_count_restart", {31'd0, bus.o_wb_stall}, 32'd0);
        issue(1'b0, 4'hF, 30'd3, 32'h0, 1'b0, 32'hCAFE0033);
        chk("abort_full_again", {31'd0, bus.o_wb_stall}, 32'd1);
        drain();

        // Reset with one response in flight.
        issue(1'b1, 4'hF, 30'd20, 32'h0BAD_F00D, 1'b0, 32'h0);
        drain();
        issue(1'b0, 4'hF, 30'd20, 32'h0, 1'b0, 32'h0BADF00D);
        bus.i_wb_stb   = 1'b0;
        bus.i_wb_cycle = 1'b0;
        reset = 1'b1;
        flushed += exp_q.size();
        exp_q.delete();
        @(negedge clk);
        chk("midreset_ack", {31'd0, bus.o_wb_ack}, 32'd0);
        chk("midreset_data", bus.o_wb_data, 32'd0);
        chk("midreset_stall", {31'd0, bus.o_wb_stall}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        issue(1'b0, 4'hF, 30'd20, 32'h0, 1'b0, 32'h0BADF00D);
        drain();

        // Upper address bits: aliasing by default, error response when enabled.
`ifdef WB_DMEM_ERR_EN
        issue(1'b1, 4'hF, 30'h4005, 32'h12345678, 1'b1, 32'h0);
        issue(1'b0, 4'hF, 30'h0005, 32'h0, 1'b0, 32'hDEADBEEF);
        issue(1'b0, 4'hF, 30'h4005, 32'h0, 1'b1, 32'h0);
`else
        issue(1'b1, 4'hF, 30'h4005, 32'h12345678, 1'b0, 32'h0);
        issue(1'b0, 4'hF, 30'h0005, 32'h0, 1'b0, 32'h12345678);
        issue(1'b0, 4'hF, 30'h8009, 32'h0, 1'b0, 32'hAA22CCDD);
`endif
        drain();
        bus.i_wb_cycle = 1'b0;
        repeat (4) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_dmem_slave.md
Name: wb_dmem_slave

Overview:
- Pipelined Wishbone B4 responder that backs the data memory port driven by the pipeline's memory stage.
- Holds a word-addressed synchronous RAM and accepts byte-selected reads and writes.
- Returns ack with a fixed, parameterised latency.
- Applies back-pressure through stall when too many responses are outstanding.

Parameters:
- ADDR_WIDTH, 14, RAM depth is 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 0, extra response delay cycles (legal 0..3); ack latency = 1 + WAIT_STATES.
- MAX_OUTSTANDING, 2, accepted-but-unacked requests allowed before stall (legal 1..4).

Ports:
- clk  input  1  system clock; everything is sampled on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_wb_cycle  input  1  bus cycle active.
- i_wb_stb  input  1  request strobe.
- i_wb_we  input  1  1 = write, 0 = read.
- i_wb_sel  input  4  byte lane enables; lane n = data bits [8n+7:8n].
- i_wb_addr  input  30  word address.
- i_wb_data  input  32  write data.
- o_wb_ack  output  1  one-cycle response strobe per accepted request.
- o_wb_data  output  32  read data, valid only while o_wb_ack=1.
- o_wb_stall  output  1  request not accepted this cycle.

Behaviour:
- Reset values:
  - o_wb_ack=0, o_wb_data=0, o_wb_stall=0.
  - Outstanding count=0 and response pipeline cleared.
  - RAM contents are not reset.
- Accept condition: i_wb_cycle & i_wb_stb & !o_wb_stall at a rising edge.
- RAM access on acceptance:
  - The RAM is accessed at the accepting edge.
  - Write: only lanes with sel=1 are updated. sel=4'b0000 is a no-op that is still acked.
  - Read: the full word at addr[ADDR_WIDTH-1:0] is captured into the response pipeline. Byte and half extraction and sign extension are the master's job.
- Addressing: upper address bits [29:ADDR_WIDTH] are ignored, so the RAM aliases.
- Ordering: requests are strictly in order. A read immediately after a write to the same word returns the new data.
- Response timing:
  - o_wb_ack is high for exactly one cycle, 1+WAIT_STATES cycles after the accepting edge.
  - Back-to-back requests give back-to-back acks.
  - o_wb_data = captured read word in the ack cycle. It is 0 for write acks and in all non-ack cycles.
- Outstanding counter:
  - +1 on accept, -1 on ack; accept and ack in the same cycle leave it unchanged.
  - Never exceeds MAX_OUTSTANDING.
- Stall: o_wb_stall = (count == MAX_OUTSTANDING) & !o_wb_ack_next. The second term allows same-cycle retire-and-accept when the head response acks this cycle.
- Control states:
  - IDLE (count 0), BUSY (0 < count < MAX), FULL (count == MAX).
  - A transition is driven only by accept/ack events.
- i_wb_cycle drops while count > 0 (abort):
  - All in-flight responses are flushed and the count is cleared the next cycle.
  - No ack is issued for them.
  - Writes already accepted stay committed.
- i_wb_stb=1 while i_wb_cycle=0: ignored.
- Reset mid-operation: behaves exactly as a reset from idle. Pending acks are dropped and the pipeline is cleared.

Optional Feature:
- Macro: WB_DMEM_ERR_EN.
- Defined:
  - Adds output o_wb_err (1 bit, reset 0).
  - A request with any of addr[29:ADDR_WIDTH] nonzero is still accepted and counted.
  - Its write is suppressed.
  - It responds with o_wb_err=1 instead of o_wb_ack, at the same latency, with o_wb_data=0.
  - Ack and err are never both high.
- Undefined: the port does not exist and out-of-range addresses alias.

Test Plan:
- Write 0xDEADBEEF to addr 5 with sel=1111, then read addr 5 -> read ack 1+WAIT_STATES cycles after accept, o_wb_data=0xDEADBEEF; write ack carries data 0.
- Write 0xAABBCCDD to addr 9 with sel=1111, then 0x11223344 with sel=0100 -> read addr 9 returns 0xAA22CCDD.
- WAIT_STATES=2, MAX_OUTSTANDING=2: hold 4 reads to addrs 0..3 on consecutive cycles:
  - stall rises after the 2nd accept;
  - all 4 acks arrive in order with the matching data;
  - count never exceeds 2.
- Issue 2 reads, drop i_wb_cycle before either ack -> no ack; count returns to 0; the next request is acked normally.
- Assert reset with 1 response in flight -> no ack; all outputs 0 the next cycle; earlier RAM writes preserved.
- With WB_DMEM_ERR_EN, ADDR_WIDTH=14: write 0x12345678 to addr 0x4005, then read addr 0x0005 -> o_wb_err for the write; old data unchanged at word 5. Without the macro, the same write lands at word 5.
